elastic_buffer: RTL

Parametrised ready/valid elastic buffer, the backpressure-capable successor to the single-stage valid/data register stage. Holds up to DEPTH words in a circular register array, decouples upstream and downstream stall timing, and reports occupancy. It sits between pipeline stages wherever a consumer can stall, and carries no combinational path from downstream ready to upstream ready.

---
 rtl/elastic_buffer.sv | 83 ++++++++
 1 files changed

// File: rtl/elastic_buffer.sv
// elastic_buffer: ready/valid elastic buffer built on a DEPTH-entry circular register array.
// Define ELASTIC_BUFFER_STALL_CNT_EN to add the 16-bit saturating stall_cnt output.
module elastic_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         valid_bit_in,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic                         ready_out,
  output logic                         valid_bit_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  input  logic                         ready_in,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef ELASTIC_BUFFER_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;

  // Handshake flags come from count alone, so ready_in never reaches ready_out.
  assign ready_out     = (count != FULL_CNT);
  assign valid_bit_out = (count != '0);
  assign data_out      = mem[rd_ptr];
  assign push          = valid_bit_in && ready_out;
  assign pop           = valid_bit_out && ready_in;

  // Explicit compare-and-wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ELASTIC_BUFFER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      stall_cnt <= '0;
    end else if (valid_bit_out && !ready_in && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
